// File: rtl/scnn_pkg.sv
// Shared definitions for the SCNN accumulator buffer.
//   LANES_DEF/PROD_W_DEF/ACC_W_DEF/DEPTH_DEF : default geometry
//   INVALID_CORD                             : coordinate marking an unused lane
//   state_t                                  : controller states
package scnn_pkg;
    localparam int LANES_DEF  = 16;
    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int DEPTH_DEF  = 256;

    localparam logic [7:0] INVALID_CORD = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/scnn_lane_pick.sv
// Lowest-index priority encoder over the pending-lane mask.
//   mask : one bit per lane still waiting to be accumulated
//   idx  : index of the lowest set bit (0 when none set)
//   any  : at least one bit set
module scnn_lane_pick #(
    parameter int LANES = 16
) (
    input  logic [LANES-1:0] mask,
    output logic [3:0]       idx,
    output logic             any
);
    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int n = LANES - 1; n >= 0; n--) begin
            if (mask[n]) begin
                idx = 4'(n);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/scnn_accum_buffer.sv
// SCNN scatter-accumulate buffer. Takes bundles of LANES signed products with
// per-lane output coordinates, adds them one lane per cycle into a saturating
// accumulator array, and on request streams out and clears the first
// drain_len entries.
//   clk, rst_n                    : clock, synchronous active-low reset
//   in_valid/in_ready             : bundle handshake
//   in_prod, in_cords             : per-lane products and coordinates (8'hFF = unused)
//   drain_req, drain_len          : start a drain of drain_len entries (0 or >DEPTH = all)
//   out_valid/out_ready           : drained-entry handshake
//   out_addr, out_data, out_last  : drained entry and end marker
//   drain_done                    : one-cycle pulse after the final drain handshake
//
// state | meaning
// IDLE  | ready for a bundle or drain request
// ACCUM | adding pending lanes of the held bundle, one per cycle
// DRAIN | streaming entries 0..drain_len-1 out and clearing them
module scnn_accum_buffer
    import scnn_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*PROD_W-1:0] in_prod,
    input  logic [LANES*8-1:0]      in_cords,
    input  logic                    drain_req,
    input  logic [8:0]              drain_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_addr,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_last,
    output logic                    drain_done
);
    localparam int AW = $clog2(DEPTH);

    state_t                  state, state_nxt;
    logic [LANES*PROD_W-1:0] prod_q;
    logic [LANES*8-1:0]      cord_q;
    logic [LANES-1:0]        mask_q, mask_new, mask_clr;
    logic [3:0]              pick_idx;
    logic                    pick_any;
    logic [ACC_W-1:0]        acc [DEPTH];
    logic [7:0]              drain_addr, last_addr, last_eff;
    logic                    done_q;
    logic                    accept, start_drain, drain_hs, drain_end;
    logic [7:0]              pick_cord;
    logic [PROD_W-1:0]       pick_prod;
    logic [ACC_W:0]          sum_wide;
    logic [ACC_W-1:0]        sum_sat;

    scnn_lane_pick #(.LANES(LANES)) u_pick (
        .mask (mask_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign in_ready    = (state == IDLE) && rst_n;
    assign start_drain = in_ready && drain_req;
    assign accept      = in_ready && in_valid && !drain_req;
    assign drain_hs    = (state == DRAIN) && out_ready;
    assign drain_end   = drain_hs && (drain_addr == last_addr);

    always_comb begin
        mask_new = '0;
        for (int n = 0; n < LANES; n++) begin
            mask_new[n] = (in_cords[n*8 +: 8] != INVALID_CORD) &&
                          (int'(in_cords[n*8 +: 8]) < DEPTH);
        end
    end

    always_comb begin
        mask_clr           = mask_q;
        mask_clr[pick_idx] = 1'b0;
    end

    always_comb begin
        last_eff = 8'(drain_len - 9'd1);
        if (drain_len == 9'd0 || int'(drain_len) > DEPTH) begin
            last_eff = 8'(DEPTH - 1);
        end
    end

    // Saturating add: one guard bit detects overflow in either direction.
    assign pick_cord = cord_q[pick_idx*8 +: 8];
    assign pick_prod = prod_q[pick_idx*PROD_W +: PROD_W];
    assign sum_wide  = {acc[pick_cord[AW-1:0]][ACC_W-1], acc[pick_cord[AW-1:0]]} +
                       {{(ACC_W+1-PROD_W){pick_prod[PROD_W-1]}}, pick_prod};

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_drain)               state_nxt = DRAIN;
                else if (accept && |mask_new)  state_nxt = ACCUM;
            end
            ACCUM:   if (mask_clr == '0) state_nxt = IDLE;
            DRAIN:   if (drain_end)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q     <= '0;
            prod_q     <= '0;
            cord_q     <= '1;
            drain_addr <= '0;
            last_addr  <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                prod_q <= in_prod;
                cord_q <= in_cords;
                mask_q <= mask_new;
            end
            if (state == ACCUM && pick_any) begin
                acc[pick_cord[AW-1:0]] <= sum_sat;
                mask_q                 <= mask_clr;
            end
            if (start_drain) begin
                drain_addr <= '0;
                last_addr  <= last_eff;
            end
            if (drain_hs) begin
                acc[drain_addr[AW-1:0]] <= '0;
                if (drain_end) done_q     <= 1'b1;
                else           drain_addr <= drain_addr + 8'd1;
            end
        end
    end

    assign out_valid  = (state == DRAIN);
    assign out_addr   = out_valid ? drain_addr : '0;
    assign out_data   = out_valid ? acc[drain_addr[AW-1:0]] : '0;
    assign out_last   = out_valid && (drain_addr == last_addr);
    assign drain_done = done_q;
endmodule

// File: tb/tb_scnn_accum_buffer.sv
module tb_scnn_accum_buffer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_prod;
    logic [127:0] in_cords;
    logic         drain_req;
    logic [8:0]   drain_len;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_addr;
    logic [23:0]  out_data;
    logic         out_last;
    logic         drain_done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scnn_accum_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_cords   (in_cords),
        .drain_req  (drain_req),
        .drain_len  (drain_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .drain_done (drain_done)
    );

    typedef struct {
        logic [3:0][15:0] p;
        logic [3:0][7:0]  c;
        int               busy;
        int               dlen;
        int               chk;
        logic [23:0]      exp;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3,
                                input logic [7:0] c0, c1, c2, c3,
                                input int busy, dlen, chk, input logic [23:0] exp);
        vec_t v;
        v.p = {p3, p2, p1, p0};
        v.c = {c3, c2, c1, c0};
        v.busy = busy; v.dlen = dlen; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [255:0] prod, input logic [127:0] cords, output int busy);
        in_prod  = prod;
        in_cords = cords;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        busy = 0;
        while (!in_ready && busy < 40) begin
            busy++;
            step();
        end
    endtask

    // Drains len entries; every entry must be zero except chk, which must hold exp.
    task automatic drain(input int len, input int chk, input logic [23:0] exp);
        int eff;
        int t;
        eff = (len == 0 || len > 256) ? 256 : len;
        drain_req = 1'b1;
        drain_len = 9'(len);
        out_ready = 1'b1;
        step();
        drain_req = 1'b0;
        in_valid  = 1'b0;
        for (int a = 0; a < eff; a++) begin
            t = 0;
            while (!out_valid && t < 10) begin
                t++;
                step();
            end
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_addr", 32'(out_addr), 32'(a));
            check("drain_data", 32'(out_data), (a == chk) ? 32'(exp) : 32'd0);
            check("drain_last", 32'(out_last), (a == eff - 1) ? 32'd1 : 32'd0);
            step();
        end
        check("drain_done", 32'(drain_done), 32'd1);
        step();
        check("drain_done_pulse", 32'(drain_done), 32'd0);
        check("ready_after_drain", 32'(in_ready), 32'd1);
    endtask

    vec_t         vecs[6];
    logic [255:0] p_v;
    logic [127:0] c_v;
    int           busy;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_cords = '1;
        drain_req = 1'b0; drain_len = '0; out_ready = 1'b1;

        vecs[0] = mk(16'd5, 16'd0, 16'd0, 16'd0, 8'd3, 8'hFF, 8'hFF, 8'hFF, 1, 4, 3, 24'd5);
        vecs[1] = mk(16'd1, 16'd2, 16'd3, 16'd4, 8'd7, 8'd7, 8'd7, 8'd7, 4, 8, 7, 24'd10);
        vecs[2] = mk(16'd0, 16'd0, 16'd0, 16'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 24'd0);
        vecs[3] = mk(16'hFFFD, 16'd10, 16'd0, 16'd0, 8'd2, 8'd2, 8'hFF, 8'hFF, 2, 3, 2, 24'd7);
        vecs[4] = mk(16'd0, 16'hFF9C, 16'd50, 16'd0, 8'hFF, 8'd5, 8'd5, 8'hFF, 2, 6, 5, 24'hFFFFCE);
        vecs[5] = mk(16'd0, 16'd0, 16'd0, 16'h7FFF, 8'hFF, 8'hFF, 8'hFF, 8'd0, 1, 1, 0, 24'h007FFF);

        step(); step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            p_v = '0;
            c_v = '1;
            for (int l = 0; l < 4; l++) begin
                p_v[l*16 +: 16] = vecs[i].p[l];
                c_v[l*8 +: 8]   = vecs[i].c[l];
            end
            send(p_v, c_v, busy);
            check("busy_cycles", 32'(busy), 32'(vecs[i].busy));
            drain(vecs[i].dlen, vecs[i].chk, vecs[i].exp);
        end

        // Positive saturation: 16 x 16 x 32767 + 248 = 8388600, then +100.
        for (int b = 0; b < 16; b++) begin
            send({16{16'h7FFF}}, '0, busy);
            if (b == 0) check("busy_full_bundle", 32'(busy), 32'd16);
        end
        send(256'd248, {{15{8'hFF}}, 8'h00}, busy);
        send(256'd100, {{15{8'hFF}}, 8'h00}, busy);
        drain(1, 0, 24'h7FFFFF);

        // Negative saturation: 16 x 16 x -32768 = -8388608, then -1.
        for (int b = 0; b < 16; b++) send({16{16'h8000}}, '0, busy);
        send({240'd0, 16'hFFFF}, {{15{8'hFF}}, 8'h00}, busy);
        drain(1, 0, 24'h800000);

        // Entries beyond drain_len keep their value.
        send({240'd0, 16'd11}, {{15{8'hFF}}, 8'd10}, busy);
        drain(4, 0, 24'd0);
        drain(11, 10, 24'd11);

        // Stalled drain: out_ready 1,0,0,1.
        send({224'd0, 16'd4, 16'd9}, {{14{8'hFF}}, 8'd0, 8'd1}, busy);
        check("busy_two_lane", 32'(busy), 32'd2);
        drain_req = 1'b1; drain_len = 9'd2; out_ready = 1'b1;
        step();
        drain_req = 1'b0;
        check("stall_addr0", 32'(out_addr), 32'd0);
        check("stall_data0", 32'(out_data), 32'd4);
        check("stall_last0", 32'(out_last), 32'd0);
        step();
        out_ready = 1'b0;
        check("stall_addr1", 32'(out_addr), 32'd1);
        check("stall_data1", 32'(out_data), 32'd9);
        check("stall_last1", 32'(out_last), 32'd1);
        for (int s = 0; s < 2; s++) begin
            step();
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_addr", 32'(out_addr), 32'd1);
            check("stall_hold_data", 32'(out_data), 32'd9);
            check("stall_no_done", 32'(drain_done), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("stall_done", 32'(drain_done), 32'd1);
        check("stall_idle_valid", 32'(out_valid), 32'd0);
        step();
        check("stall_done_pulse", 32'(drain_done), 32'd0);

        // drain_req and in_valid together: drain wins, bundle dropped.
        in_prod  = {240'd0, 16'd77};
        in_cords = {{15{8'hFF}}, 8'd4};
        in_valid = 1'b1;
        drain(5, 4, 24'd0);

        // Reset in the middle of ACCUM.
        send({240'd0, 16'd3}, {{15{8'hFF}}, 8'd20}, busy);
        in_prod  = {192'd0, 16'd1, 16'd1, 16'd1, 16'd1};
        in_cords = {{12{8'hFF}}, 8'd9, 8'd9, 8'd9, 8'd9};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("accum_busy", 32'(in_ready), 32'd0);
        drain_req = 1'b1;
        drain_len = 9'd1;
        step();
        check("drain_ignored_accum", 32'(out_valid), 32'd0);
        drain_req = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_idle", 32'(in_ready), 32'd1);
        drain(0, 0, 24'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/scnn_accum_buffer.md
SCNN_ACCUM_BUFFER -- requirements
Module: scnn_accum_buffer

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning), one per line:
- LANES, 16, products per input bundle (4 weights x 4 inputs)
- PROD_W, 16, signed product width
- ACC_W, 24, signed accumulator width
- DEPTH, 256, accumulator entries, addressed by 8-bit output coordinate
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock
- rst_n, in, 1, synchronous active-low reset
- in_valid, in, 1, product bundle valid
- in_ready, out, 1, block can accept a bundle
- in_prod, in, LANES x PROD_W, signed products; lane n = wt f, ip i with n = 4f+i
- in_cords, in, LANES x 8, output coordinate per lane; 8'hFF means invalid lane
- drain_req, in, 1, request to stream out and clear the buffer
- drain_len, in, 9, number of entries to drain (1..256), sampled with drain_req
- out_valid, out, 1, drained entry valid
- out_ready, in, 1, consumer accepts drained entry
- out_addr, out, 8, coordinate of the drained entry
- out_data, out, ACC_W, accumulated value
- out_last, out, 1, final drained entry
- drain_done, out, 1, one-cycle pulse after the last entry is accepted
REQ-003 Clock and reset SHALL be exactly one clock, clk, and reset rst_n, synchronous and active-low.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCUM, DRAIN.
REQ-005 In IDLE, in_ready SHALL be 1. In ACCUM and DRAIN, in_ready SHALL be 0.
REQ-006 A bundle SHALL be accepted when in_valid && in_ready. On acceptance, the block SHALL register the products and coordinates and set a pending mask bit for each lane whose cord is not 8'hFF and is less than DEPTH.
REQ-007 In ACCUM, each cycle SHALL process the lowest-indexed pending lane: acc[cord] <= sat(acc[cord] + sign-extended prod), then clear that lane's mask bit.
REQ-008 A bundle with k valid lanes SHALL occupy exactly k cycles in ACCUM, then return to IDLE. For k=0, the FSM SHALL stay in IDLE and in_ready SHALL remain 1.
REQ-009 Lanes in one bundle that share a coordinate SHALL each be accumulated, in lane order, with no update lost.
REQ-010 Addition SHALL saturate to the signed ACC_W range: +2^(ACC_W-1)-1 on overflow and -2^(ACC_W-1) on underflow.
REQ-011 drain_req SHALL be honoured only in IDLE. If it arrives in ACCUM, it SHALL be ignored; requesters hold it until in_ready=1.
REQ-012 If drain_req and in_valid are both high in IDLE, drain SHALL take priority and the bundle SHALL NOT be accepted.
REQ-013 In DRAIN:
- The block SHALL present entries at addresses 0..drain_len-1, in order.
- out_valid SHALL be 1; out_addr and out_data SHALL be held stable while out_ready=0.
- On each handshake, the entry SHALL be cleared to 0 and the address SHALL advance.
REQ-014 out_last SHALL be 1 only together with address drain_len-1.
REQ-015 After the last handshake, the block SHALL pulse drain_done for one cycle and return to IDLE.
REQ-016 A drain_len of 0 or greater than 256 SHALL be treated as 256.
REQ-017 Entries at or beyond drain_len SHALL keep their values.

Reset
REQ-018 While rst_n=0 at a clk edge, the block SHALL enter IDLE and clear the pending mask. Outputs SHALL be: out_valid=0, out_last=0, drain_done=0, out_addr=0, out_data=0, in_ready=0. in_ready SHALL become 1 on the first cycle after reset is released.
REQ-019 Reset SHALL clear all DEPTH accumulator entries to 0 within the reset cycle (flop array). Reset during ACCUM or DRAIN SHALL abandon the operation without emitting further outputs.

Structure
REQ-020 A shared package scnn_pkg SHALL hold the LANES, PROD_W, ACC_W and DEPTH defaults, the INVALID_CORD (8'hFF) constant and the state enum.
REQ-021 The lowest-pending-lane priority encoder SHALL be a sub-module, scnn_lane_pick. Its input SHALL be the LANES-bit mask; its outputs SHALL be a 4-bit index and an any-pending flag.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Bundle with lane 0: prod=5, cord=3; lanes 1-15: cord=FF; then drain_len=4 -> out 0,0,0,5 at addr 0..3, out_last on addr 3; acc[3]=0 afterwards.
- Lanes 0-3: prod=1,2,3,4, all cord=7; others FF -> in_ready low exactly 4 cycles; drain yields acc[7]=10.
- All 16 lanes cord=FF -> in_ready never drops; drain returns all zeros.
- acc[0]=8388600, then add prod=100 to cord 0 -> drained value 8388607; the negative case yields -8388608.
- Drain drain_len=2 with out_ready toggling 1,0,0,1 -> addr/data stable while stalled; drain_done one cycle after addr 1 handshake.
- drain_req and in_valid high together in IDLE -> drain runs, bundle not accepted. Reset asserted mid-ACCUM -> all entries 0, IDLE next cycle.
